// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares the single write port of one FIFO between
//   NUM_REQ producers. Each grant is a burst of up to BURST_LEN beats, and
//   accepted beats reach the FIFO one cycle later through registered outputs.
//   FIFO almost_full gates req_ready, so the FIFO is never written while full
//   provided its almost-full threshold is at least one.
//   Optional feature: define FIFO_ARB_STATS_EN to get a per-requester counter
//   of written beats on stat_beats. Otherwise stat_beats is tied to zero and
//   stat_clr is ignored.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_almost_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    input  logic                          stat_clr,
    output logic [NUM_REQ*CNT_W-1:0]      stat_beats
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [BW-1:0]   beat_cnt;
    logic [GW-1:0]   next_grant;
    logic [GW-1:0]   cand;
    logic            found;
    logic            handshake;
    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

    // Unpack the flat requester data bus into one word per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first valid requester after last_grant, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path
        // through this block can leave one unassigned and infer a latch.
        next_grant = last_grant;
        cand       = '0;
        found      = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                next_grant = cand;
                found      = 1'b1;
            end
        end
    end

    assign handshake = (state == BURST) && req_valid[grant_id] && !fifo_almost_full;
    assign busy      = (state == BURST);

    // Only the granted requester sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (state == BURST) begin
            req_ready[grant_id] = ~fifo_almost_full;
        end
    end

    // Arbitration FSM and registered write path.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state        <= IDLE;
            last_grant   <= LAST_REQ;
            grant_id     <= '0;
            beat_cnt     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_en <= handshake;
            if (handshake) begin
                fifo_wr_data <= req_words[grant_id];
            end
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id   <= next_grant;
                        last_grant <= next_grant;
                        beat_cnt   <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (!req_valid[grant_id]) begin
                        state <= IDLE;
                    end else if (handshake) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] stat_cnt [NUM_REQ];

    // Per-requester beat counters; clear or reset wins over an increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            // NOTE: this array is a handful of architecturally visible
            // counters, so it is reset; bulk storage arrays normally are not.
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else if (handshake) begin
            stat_cnt[grant_id] <= stat_cnt[grant_id] + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat_pack
        assign stat_beats[i*CNT_W +: CNT_W] = stat_cnt[i];
    end
`else
    logic unused_stat_clr;

    assign stat_beats      = '0;
    assign unused_stat_clr = stat_clr;
`endif

endmodule
